lcd_digit_driver: RTL

Write-only HD44780 driver that consumes the six BCD digits produced by the score BCD converters (tens/ones for each of the three display values) and drives a 16x2 character LCD in 8-bit mode. It sits directly downstream of the BCD stage inside the LCD top level. It performs the power-up initialisation sequence, then refreshes line 1 continuously. Each frame is a coherent snapshot of the digits.

---
 rtl/lcd_digit_driver.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/lcd_digit_driver.sv
// lcd_digit_driver: write-only HD44780 driver for a 16x2 LCD in 8-bit mode.
// Runs the power-up init sequence, then refreshes line 1 endlessly with
// "A:t1o1 B:t2o2 C:t3o3  " built from a per-frame snapshot of the BCD digits.
module lcd_digit_driver #(
  parameter int POWERUP_CYC    = 750000,
  parameter int EN_CYC         = 25,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLEAR_WAIT_CYC = 100000
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic [3:0] tens1,
  input  logic [3:0] ones1,
  input  logic [3:0] tens2,
  input  logic [3:0] ones2,
  input  logic [3:0] tens3,
  input  logic [3:0] ones3,
  output logic       ready,
  output logic       frame_done,
  output logic       LCD_ON,
  output logic       LCD_BLON,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic [7:0] LCD_DATA
);

  // One shared counter, sized for the largest interval so it never wraps.
  localparam int MAX_AB  = (POWERUP_CYC > EN_CYC) ? POWERUP_CYC : EN_CYC;
  localparam int MAX_CD  = (CMD_WAIT_CYC > CLEAR_WAIT_CYC) ? CMD_WAIT_CYC : CLEAR_WAIT_CYC;
  localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);

  // The reset cycle itself does not count, so the power-up wait compares
  // against POWERUP_CYC; the other states start at 0 on entry and end at N-1.
  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYC);
  localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_WAIT_CYC - 1);

  // Sequencer indices: 0..3 init commands, 4 = set-DDRAM 0x80, 5..20 characters.
  localparam logic [4:0] IDX_INIT_LAST = 5'd3;
  localparam logic [4:0] IDX_HOME      = 5'd4;
  localparam logic [4:0] IDX_LAST      = 5'd20;

  typedef enum logic [1:0] {PWR_WAIT, SETUP, EN_HIGH, WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       idx_q, idx_d;
  logic             en_q, en_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             ready_q, ready_d;
  logic             fd_q, fd_d;
  logic [23:0]      snap_q;
  logic [CNT_W-1:0] wait_last;
  logic [8:0]       byte_nxt;

  // BCD digit to ASCII; anything above 9 shows as '-'.
  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    return (d <= 4'd9) ? (8'h30 | {4'h0, d}) : 8'h2D;
  endfunction

  // {RS, DATA} for a sequencer index. s = {t1,o1,t2,o2,t3,o3}.
  function automatic logic [8:0] byte_sel(input logic [4:0] idx, input logic [23:0] s);
    logic [8:0] b;
    case (idx)
      5'd0:    b = {1'b0, 8'h38};
      5'd1:    b = {1'b0, 8'h0C};
      5'd2:    b = {1'b0, 8'h01};
      5'd3:    b = {1'b0, 8'h06};
      5'd4:    b = {1'b0, 8'h80};
      5'd5:    b = {1'b1, 8'h41};
      5'd6:    b = {1'b1, 8'h3A};
      5'd7:    b = {1'b1, digit_ascii(s[23:20])};
      5'd8:    b = {1'b1, digit_ascii(s[19:16])};
      5'd9:    b = {1'b1, 8'h20};
      5'd10:   b = {1'b1, 8'h42};
      5'd11:   b = {1'b1, 8'h3A};
      5'd12:   b = {1'b1, digit_ascii(s[15:12])};
      5'd13:   b = {1'b1, digit_ascii(s[11:8])};
      5'd14:   b = {1'b1, 8'h20};
      5'd15:   b = {1'b1, 8'h43};
      5'd16:   b = {1'b1, 8'h3A};
      5'd17:   b = {1'b1, digit_ascii(s[7:4])};
      5'd18:   b = {1'b1, digit_ascii(s[3:0])};
      5'd19:   b = {1'b1, 8'h20};
      5'd20:   b = {1'b1, 8'h20};
      default: b = {1'b0, 8'h00};
    endcase
    return b;
  endfunction

  // Next-state, counter, sequencer and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    en_d      = en_q;
    rs_d      = rs_q;
    data_d    = data_q;
    ready_d   = ready_q;
    fd_d      = 1'b0;
    byte_nxt  = 9'h000;
    wait_last = (!rs_q && data_q == 8'h01) ? CLR_LAST : CMD_LAST;
    case (state_q)
      PWR_WAIT: begin
        if (cnt_q == PWR_LAST) begin
          state_d  = SETUP;
          cnt_d    = '0;
          idx_d    = 5'd0;
          byte_nxt = byte_sel(5'd0, snap_q);
          rs_d     = byte_nxt[8];
          data_d   = byte_nxt[7:0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SETUP: begin
        state_d = EN_HIGH;
        cnt_d   = '0;
        en_d    = 1'b1;
      end
      EN_HIGH: begin
        if (cnt_q == EN_LAST) begin
          state_d = WAIT;
          cnt_d   = '0;
          en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == wait_last) begin
          state_d = SETUP;
          cnt_d   = '0;
          if (idx_q == IDX_INIT_LAST) begin
            idx_d   = IDX_HOME;
            ready_d = 1'b1;
          end else if (idx_q == IDX_LAST) begin
            idx_d = IDX_HOME;
            fd_d  = 1'b1;
          end else begin
            idx_d = idx_q + 5'd1;
          end
          byte_nxt = byte_sel(idx_d, snap_q);
          rs_d     = byte_nxt[8];
          data_d   = byte_nxt[7:0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = PWR_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and LCD bus registers with synchronous reset.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      state_q <= PWR_WAIT;
      cnt_q   <= '0;
      idx_q   <= 5'd0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      ready_q <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      fd_q    <= fd_d;
    end
  end

  // Digit snapshot taken during the 0x80 SETUP cycle so each frame is coherent.
  always_ff @(posedge clock_50) begin
    if (state_q == SETUP && idx_q == IDX_HOME) begin
      snap_q <= {tens1, ones1, tens2, ones2, tens3, ones3};
    end
  end

  assign ready      = ready_q;
  assign frame_done = fd_q;
  assign LCD_EN     = en_q;
  assign LCD_RS     = rs_q;
  assign LCD_DATA   = data_q;
  assign LCD_ON     = 1'b1;
  assign LCD_BLON   = 1'b1;
  assign LCD_RW     = 1'b0;

endmodule
